// File: rtl/sram_access_arbiter.sv
// Two-port arbiter in front of the shared combined_ram: round-robin per access,
// optional locked bursts with a fairness timeout, and a sticky write-protect gate.
module sram_access_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int MAX_LOCK   = 1024,
    parameter int LOCK_CNT_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wmask0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wmask1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              wp_clear,
    output logic              wp_active,
    output logic              wr_blocked,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

    state_t                state_r, state_nxt_s;
    logic                  rr_last_r, rr_last_nxt_s;
    logic [LOCK_CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
    logic                  wp_active_r, wr_blocked_r, rvalid0_r, rvalid1_r;
    logic                  gnt0_s, gnt1_s, wr_req_s;

    // Grant selection and ownership/fairness next-state logic
    always_comb begin
        gnt0_s         = 1'b0;
        gnt1_s         = 1'b0;
        state_nxt_s    = state_r;
        rr_last_nxt_s  = rr_last_r;
        lock_cnt_nxt_s = lock_cnt_r;
        case (state_r)
            IDLE: begin
                lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
                if (req0 && req1) begin
                    if (rr_last_r) gnt0_s = 1'b1;
                    else           gnt1_s = 1'b1;
                end else if (req0) begin
                    gnt0_s = 1'b1;
                end else if (req1) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
                if (gnt0_s) begin
                    rr_last_nxt_s = 1'b0;
                    state_nxt_s   = lock0 ? OWN0 : IDLE;
                end else if (gnt1_s) begin
                    rr_last_nxt_s = 1'b1;
                    state_nxt_s   = lock1 ? OWN1 : IDLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                gnt0_s = req0;
                if (!lock0) begin
                    state_nxt_s    = IDLE;
                    lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
                end else if (req1) begin
                    // Timeout hands the next tie to the waiting port
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_nxt_s    = IDLE;
                        rr_last_nxt_s  = 1'b0;
                        lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r + LOCK_CNT_W'(1);
                    end
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end
            OWN1: begin
                gnt1_s = req1;
                if (!lock1) begin
                    state_nxt_s    = IDLE;
                    lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
                end else if (req0) begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_nxt_s    = IDLE;
                        rr_last_nxt_s  = 1'b1;
                        lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r + LOCK_CNT_W'(1);
                    end
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                lock_cnt_nxt_s = {LOCK_CNT_W{1'b0}};
            end
        endcase
    end

    // RAM port mux: idle values keep the macro quiet
    always_comb begin
        ram_raddr = {ADDR_W{1'b0}};
        ram_waddr = {ADDR_W{1'b0}};
        ram_we    = 1'b0;
        ram_wdata = {DATA_W{1'b0}};
        ram_wmask = {DATA_W{1'b1}};
        if (gnt0_s) begin
            ram_raddr = addr0;
            ram_waddr = addr0;
            ram_we    = we0 & ~wp_active_r;
            ram_wdata = wdata0;
            ram_wmask = wmask0;
        end else if (gnt1_s) begin
            ram_raddr = addr1;
            ram_waddr = addr1;
            ram_we    = we1 & ~wp_active_r;
            ram_wdata = wdata1;
            ram_wmask = wmask1;
        end else begin
            ram_we = 1'b0;
        end
    end

    assign wr_req_s = (gnt0_s & we0) | (gnt1_s & we1);

    // Arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_last_r  <= 1'b1;
            lock_cnt_r <= {LOCK_CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            rr_last_r  <= rr_last_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
        end
    end

    // Read-valid tracking and the sticky write-protect gate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_active_r  <= 1'b1;
            wr_blocked_r <= 1'b0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
        end else begin
            wp_active_r  <= wp_active_r & ~wp_clear;
            wr_blocked_r <= wr_req_s & wp_active_r;
            rvalid0_r    <= gnt0_s & ~we0;
            rvalid1_r    <= gnt1_s & ~we1;
        end
    end

    assign gnt0       = gnt0_s;
    assign gnt1       = gnt1_s;
    assign rvalid0    = rvalid0_r;
    assign rvalid1    = rvalid1_r;
    assign rdata      = ram_rdata;
    assign wp_active  = wp_active_r;
    assign wr_blocked = wr_blocked_r;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized bench for sram_access_arbiter: behavioural arbitration/memory model,
// read-data scoreboard popped by an independent monitor.
module tb_sram_access_arbiter;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 16;
    localparam int MAX_LOCK = 8;
    localparam int NCYC     = 2400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit              p_req  [2];
    bit              p_we   [2];
    bit              p_lock [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [DATA_W-1:0] p_wdata [2];
    logic [DATA_W-1:0] p_wmask [2];
    logic            wp_clear = 1'b0;

    logic req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wmask0, wdata1, wmask1;
    logic gnt0, gnt1, rvalid0, rvalid1, wp_active, wr_blocked, ram_we;
    logic [DATA_W-1:0] rdata, ram_wdata, ram_wmask, ram_rdata;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;

    assign req0 = p_req[0];  assign we0 = p_we[0];  assign lock0 = p_lock[0];
    assign addr0 = p_addr[0]; assign wdata0 = p_wdata[0]; assign wmask0 = p_wmask[0];
    assign req1 = p_req[1];  assign we1 = p_we[1];  assign lock1 = p_lock[1];
    assign addr1 = p_addr[1]; assign wdata1 = p_wdata[1]; assign wmask1 = p_wmask[1];

    sram_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK), .LOCK_CNT_W(11)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .wmask0(wmask0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .wmask1(wmask1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .wp_clear(wp_clear), .wp_active(wp_active), .wr_blocked(wr_blocked),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    // Physical RAM stand-in: synchronous read, mask bit 0 = write
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= (mem[ram_waddr] & ram_wmask) | (ram_wdata & ~ram_wmask);
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rq0 [$];
    logic [DATA_W-1:0] rq1 [$];
    int owner, last, waited, cyc;
    bit wp, exp_blk;
    bit exp_rv [2];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented read response is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && rvalid0) begin
            if (rq0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
            else check("rdata0", 32'(rdata), 32'(rq0.pop_front()));
        end
        if (!rst && rvalid1) begin
            if (rq1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
            else check("rdata1", 32'(rdata), 32'(rq1.pop_front()));
        end
    end

    task automatic model_reset();
        owner = -1; last = 1; waited = 0; wp = 1'b1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_blk = 1'b0;
        rq0.delete(); rq1.delete();
    endtask

    // Called just after a rising edge; reset is held across the next edge
    task automatic do_reset();
        rst = 1'b1;
        p_req[0] = 1'b0; p_req[1] = 1'b0; p_lock[0] = 1'b0; p_lock[1] = 1'b0;
        wp_clear = 1'b0;
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_wp_active", 32'(wp_active), 32'd1);
        check("rst_wr_blocked", 32'(wr_blocked), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_wmask", 32'(ram_wmask), 32'hFFFF);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        int g;
        int o;
        logic [ADDR_W-1:0] a;
        check("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
        check("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
        check("wr_blocked", 32'(wr_blocked), 32'(exp_blk));
        check("wp_active", 32'(wp_active), 32'(wp));
        for (int n = 0; n < 2; n++) begin
            if (!p_req[n] && $urandom_range(0, 9) < 7) begin
                p_req[n]   = 1'b1;
                p_we[n]    = ($urandom_range(0, 2) == 0);
                p_addr[n]  = ADDR_W'($urandom_range(0, 31));
                p_wdata[n] = DATA_W'($urandom);
                case ($urandom_range(0, 2))
                    0:       p_wmask[n] = 16'h0000;
                    1:       p_wmask[n] = 16'h00FF;
                    default: p_wmask[n] = DATA_W'($urandom);
                endcase
            end
            if ($urandom_range(0, 7) == 0) p_lock[n] = !p_lock[n];
        end
        wp_clear = ($urandom_range(0, 149) == 0);
        #1;
        // Who should win this cycle
        g = -1;
        if (owner >= 0) begin
            if (p_req[owner]) g = owner;
        end else if (p_req[0] && p_req[1]) g = (last == 1) ? 0 : 1;
        else if (p_req[0]) g = 0;
        else if (p_req[1]) g = 1;
        check("gnt0", 32'(gnt0), 32'(g == 0));
        check("gnt1", 32'(gnt1), 32'(g == 1));
        if (g >= 0) begin
            a = p_addr[g];
            check("ram_raddr", 32'(ram_raddr), 32'(a));
            check("ram_waddr", 32'(ram_waddr), 32'(a));
            check("ram_we", 32'(ram_we), 32'(p_we[g] && !wp));
            check("ram_wdata", 32'(ram_wdata), 32'(p_wdata[g]));
            check("ram_wmask", 32'(ram_wmask), 32'(p_wmask[g]));
        end else begin
            check("idle_ram_we", 32'(ram_we), 32'd0);
            check("idle_ram_raddr", 32'(ram_raddr), 32'd0);
            check("idle_ram_wmask", 32'(ram_wmask), 32'hFFFF);
        end
        exp_rv[0] = (g == 0) && !p_we[0];
        exp_rv[1] = (g == 1) && !p_we[1];
        exp_blk   = (g >= 0) && p_we[g] && wp;
        if (g == 0 && !p_we[0]) rq0.push_back(ref_mem[p_addr[0]]);
        if (g == 1 && !p_we[1]) rq1.push_back(ref_mem[p_addr[1]]);
        if (g >= 0 && p_we[g] && !wp)
            ref_mem[p_addr[g]] = (ref_mem[p_addr[g]] & p_wmask[g]) | (p_wdata[g] & ~p_wmask[g]);
        if (wp_clear) wp = 1'b0;
        // Ownership bookkeeping
        if (owner < 0) begin
            if (g >= 0) begin
                last = g;
                if (p_lock[g]) begin owner = g; waited = 0; end
            end
        end else begin
            o = 1 - owner;
            if (!p_lock[owner]) owner = -1;
            else if (p_req[o]) begin
                if (waited == MAX_LOCK - 1) begin last = owner; owner = -1; end
                else waited++;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) p_req[g] = 1'b0;
    endtask

    initial begin
        int next_rst;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = DATA_W'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 2; n++) begin
            p_req[n] = 1'b0; p_we[n] = 1'b0; p_lock[n] = 1'b0;
            p_addr[n] = '0; p_wdata[n] = '0; p_wmask[n] = 16'hFFFF;
        end
        cyc = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        next_rst = 600;
        for (cyc = 1; cyc <= NCYC; cyc++) begin
            // Prefer resetting right after a read grant inside a locked burst
            if ((cyc >= next_rst && owner >= 0 && exp_rv[owner]) || cyc >= next_rst + 300) begin
                do_reset();
                next_rst = cyc + 600;
            end else begin
                step();
            end
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        @(negedge clk);
        #1;
        check("rq0_drained", 32'(rq0.size()), 32'd0);
        check("rq1_drained", 32'(rq1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
